// File: rtl/apb_pkg.sv
// Shared types and defaults for the arbitrated APB master.
// Holds the transfer FSM states and bus width defaults.
package apb_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

endpackage

// File: rtl/apb_arb_master_if.sv
// Requester, response and APB signal bundle for apb_arb_master.
// The master modport is the DUT side; slave is the environment side.
interface apb_arb_master_if #(
    parameter int ADDR_W = apb_pkg::ADDR_W_DEF,
    parameter int DATA_W = apb_pkg::DATA_W_DEF
);

    logic              req0_valid;
    logic              req0_ready;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req1_valid;
    logic              req1_ready;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;

    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp0_err;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              rsp1_err;

    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslvrr;

    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp0_err,
        output rsp1_valid, rsp1_rdata, rsp1_err,
        output paddr, pwrite, pwdata, psel, penable,
        input  prdata, pready, pslvrr
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp0_err,
        input  rsp1_valid, rsp1_rdata, rsp1_err,
        input  paddr, pwrite, pwdata, psel, penable,
        output prdata, pready, pslvrr
    );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin grant: on contention the requester
// not granted last wins; a lone request always wins.
module apb_rr_arbiter (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[0] && req[1]) begin
            gnt = last ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by two requesters with round-robin arbitration,
// registered bus outputs and an ACCESS-phase timeout.
module apb_arb_master #(
    parameter int ADDR_W   = apb_pkg::ADDR_W_DEF,
    parameter int DATA_W   = apb_pkg::DATA_W_DEF,
    parameter int WAIT_MAX = 15
) (
    input logic              pclk,
    input logic              preset,
    apb_arb_master_if.master bus
);

    import apb_pkg::*;

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_MAX - 1);

    state_t            state_q, state_d;
    logic [1:0]        req_v, gnt;
    logic              last_q, gnt_id_q;
    logic [CNT_W-1:0]  wait_q;
    logic              accept, done, timeout, finish;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata, rd_val;

    logic              psel_q, penable_q, pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp0_valid_q, rsp0_err_q;
    logic              rsp1_valid_q, rsp1_err_q;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp1_rdata_q;

    assign req_v = {bus.req1_valid, bus.req0_valid};

    apb_rr_arbiter u_arb (
        .req  (req_v),
        .last (last_q),
        .gnt  (gnt)
    );

    assign accept  = (state_q == IDLE) && (|req_v) && !preset;
    assign done    = (state_q == ACCESS) && bus.pready;
    assign timeout = (state_q == ACCESS) && !bus.pready
                   && (wait_q == LAST_WAIT);
    assign finish  = done || timeout;

    assign sel_write = gnt[1] ? bus.req1_write : bus.req0_write;
    assign sel_addr  = gnt[1] ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = gnt[1] ? bus.req1_wdata : bus.req0_wdata;

    // Writes return zero data regardless of what the slave drives
    assign rd_val = (done && !pwrite_q) ? bus.prdata : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            gnt_id_q     <= 1'b0;
            wait_q       <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp0_valid_q <= 1'b0;
            rsp0_err_q   <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_valid_q <= 1'b0;
            rsp1_err_q   <= 1'b0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= (state_d != IDLE);
            penable_q <= (state_d == ACCESS);
            // Counts completed ACCESS cycles of the current transfer
            if (state_q == ACCESS && state_d == ACCESS) begin
                wait_q <= wait_q + CNT_W'(1);
            end else begin
                wait_q <= '0;
            end
            if (accept) begin
                last_q   <= gnt[1];
                gnt_id_q <= gnt[1];
                pwrite_q <= sel_write;
                paddr_q  <= sel_addr;
                pwdata_q <= sel_wdata;
            end
            rsp0_valid_q <= finish && !gnt_id_q;
            rsp0_err_q   <= finish && !gnt_id_q
                         && (timeout || bus.pslvrr);
            rsp0_rdata_q <= gnt_id_q ? '0 : rd_val;
            rsp1_valid_q <= finish && gnt_id_q;
            rsp1_err_q   <= finish && gnt_id_q
                         && (timeout || bus.pslvrr);
            rsp1_rdata_q <= gnt_id_q ? rd_val : '0;
        end
    end

    assign bus.req0_ready = accept && gnt[0];
    assign bus.req1_ready = accept && gnt[1];
    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.paddr      = paddr_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp0_err   = rsp0_err_q;
    assign bus.rsp0_rdata = rsp0_rdata_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp1_err   = rsp1_err_q;
    assign bus.rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: transaction-level model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_apb_arb_master;

    localparam int WMAX = 15;

    logic pclk = 1'b0;
    logic preset = 1'b1;
    always #5 pclk = ~pclk;

    apb_arb_master_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    apb_arb_master #(
        .ADDR_W   (6),
        .DATA_W   (32),
        .WAIT_MAX (WMAX)
    ) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    typedef struct {
        bit        write;
        bit [5:0]  addr;
        bit [31:0] wdata;
        int        delay;
        bit        err;
    } txn_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    txn_t        q0[$];
    txn_t        q1[$];
    rsp_t        rlog[$];
    logic [31:0] mem [64];

    int tests = 0;
    int fails = 0;

    // Model: age 1 = SETUP, 2..1+len = ACCESS, 2+len = response
    txn_t        m_cur = '{1'b0, 6'h0, 32'h0, 0, 1'b0};
    bit          m_busy = 1'b0;
    bit          m_last = 1'b1;
    bit          m_g = 1'b0;
    int          m_age = 0;
    int          m_len = 0;
    logic [31:0] m_rdata = '0;
    bit          m_err = 1'b0;
    int          psel_cnt = 0;
    int          pen_cnt = 0;

    // Slave: ready after m_cur.delay waited ACCESS cycles; junk elsewhere
    assign bus.pready = (bus.psel && bus.penable)
                      ? (m_age - 2 == m_cur.delay) : 1'b1;
    assign bus.pslvrr = (bus.psel && bus.penable) ? m_cur.err : 1'b1;
    assign bus.prdata = (bus.psel && bus.penable && !bus.pwrite)
                      ? mem[bus.paddr] : 32'hDEADBEEF;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act,
                        input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic drive();
        bus.req0_valid = (q0.size() != 0);
        bus.req1_valid = (q1.size() != 0);
        bus.req0_write = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_wdata = '0;
        bus.req1_write = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_wdata = '0;
        if (q0.size() != 0) begin
            bus.req0_write = q0[0].write;
            bus.req0_addr  = q0[0].addr;
            bus.req0_wdata = q0[0].wdata;
        end
        if (q1.size() != 0) begin
            bus.req1_write = q1[0].write;
            bus.req1_addr  = q1[0].addr;
            bus.req1_wdata = q1[0].wdata;
        end
    endtask

    always @(posedge pclk) begin
        #1;
        if (preset) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            m_age  = 0;
        end else if (m_busy && m_age < 2 + m_len) begin
            if (m_age == 1 + m_len && m_cur.write && !m_err)
                mem[m_cur.addr] = m_cur.wdata;
            m_age++;
        end else begin
            m_busy = 1'b0;
            if (bus.req0_valid || bus.req1_valid) begin
                m_g = (bus.req0_valid && bus.req1_valid)
                    ? !m_last : bus.req1_valid;
                m_cur  = m_g ? q1.pop_front() : q0.pop_front();
                m_last = m_g;
                if (m_cur.delay + 1 <= WMAX) begin
                    m_len   = m_cur.delay + 1;
                    m_err   = m_cur.err;
                    m_rdata = m_cur.write ? 32'h0 : mem[m_cur.addr];
                end else begin
                    m_len   = WMAX;
                    m_err   = 1'b1;
                    m_rdata = 32'h0;
                end
                m_busy = 1'b1;
                m_age  = 1;
            end
        end
        #1;
        drive();
    end

    always @(negedge pclk) begin : cmp
        bit       rsp_now, idle_now, e_psel, e_pen;
        bit [1:0] e_rdy;
        rsp_now  = m_busy && (m_age == 2 + m_len);
        idle_now = !m_busy || rsp_now;
        e_psel   = m_busy && (m_age <= 1 + m_len);
        e_pen    = m_busy && (m_age >= 2) && (m_age <= 1 + m_len);
        e_rdy    = 2'b00;
        if (idle_now && !preset) begin
            if (bus.req0_valid && bus.req1_valid)
                e_rdy = m_last ? 2'b01 : 2'b10;
            else
                e_rdy = {bus.req1_valid, bus.req0_valid};
        end
        chkb("psel", bus.psel, e_psel);
        chkb("penable", bus.penable, e_pen);
        chkb("req0_ready", bus.req0_ready, e_rdy[0]);
        chkb("req1_ready", bus.req1_ready, e_rdy[1]);
        chkb("rsp0_valid", bus.rsp0_valid, rsp_now && !m_g);
        chkb("rsp1_valid", bus.rsp1_valid, rsp_now && m_g);
        if (e_psel) begin
            chk("paddr", 32'(bus.paddr), 32'(m_cur.addr));
            chkb("pwrite", bus.pwrite, m_cur.write);
            chk("pwdata", bus.pwdata, m_cur.wdata);
        end
        if (rsp_now) begin
            chk("rsp_rdata", m_g ? bus.rsp1_rdata : bus.rsp0_rdata,
                m_rdata);
            chkb("rsp_err", m_g ? bus.rsp1_err : bus.rsp0_err, m_err);
        end
        if (bus.psel) psel_cnt++;
        if (bus.penable) pen_cnt++;
        if (bus.rsp0_valid)
            rlog.push_back('{0, bus.rsp0_rdata, bus.rsp0_err});
        if (bus.rsp1_valid)
            rlog.push_back('{1, bus.rsp1_rdata, bus.rsp1_err});
    end

    task automatic clear_mon();
        psel_cnt = 0;
        pen_cnt  = 0;
        rlog.delete();
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((m_busy || q0.size() != 0 || q1.size() != 0)
               && n < maxc) begin
            @(posedge pclk);
            #3;
            n++;
        end
        chkb("wait_idle", n < maxc, 1'b1);
    endtask

    task automatic chk_rsp(input string nm, input int idx, input int id,
                           input logic [31:0] rd, input logic err);
        chkb({nm, "_present"}, rlog.size() > idx, 1'b1);
        if (rlog.size() > idx) begin
            chk({nm, "_id"}, 32'(rlog[idx].id), 32'(id));
            chk({nm, "_rdata"}, rlog[idx].rdata, rd);
            chkb({nm, "_err"}, rlog[idx].err, err);
        end
    endtask

    task automatic reset_pulse();
        preset = 1'b1;
        @(posedge pclk);
        #3;
        preset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        drive();
        repeat (3) @(posedge pclk);
        #3;
        preset = 1'b0;
        chk("rst_paddr", 32'(bus.paddr), 32'h0);
        chk("rst_pwdata", bus.pwdata, 32'h0);
        chkb("rst_pwrite", bus.pwrite, 1'b0);
        chk("rst_rsp0_rdata", bus.rsp0_rdata, 32'h0);

        clear_mon();
        q0.push_back('{1'b1, 6'h00, 32'hA5A5A5A5, 0, 1'b0});
        wait_idle(20);
        chk("wr_psel_cycles", 32'(psel_cnt), 32'd2);
        chk("wr_pen_cycles", 32'(pen_cnt), 32'd1);
        chk_rsp("wr_rsp", 0, 0, 32'h0, 1'b0);

        clear_mon();
        q0.push_back('{1'b0, 6'h00, 32'h0, 0, 1'b0});
        wait_idle(20);
        chk("rd_psel_cycles", 32'(psel_cnt), 32'd2);
        chk_rsp("rd_rsp", 0, 0, 32'hA5A5A5A5, 1'b0);

        reset_pulse();
        clear_mon();
        q0.push_back('{1'b1, 6'h01, 32'h11, 0, 1'b0});
        q0.push_back('{1'b0, 6'h03, 32'h0, 1, 1'b0});
        q1.push_back('{1'b1, 6'h03, 32'h33, 2, 1'b0});
        q1.push_back('{1'b0, 6'h01, 32'h0, 0, 1'b0});
        wait_idle(80);
        chk("rr_rsp_count", 32'(rlog.size()), 32'd4);
        chk_rsp("rr0", 0, 0, 32'h0, 1'b0);
        chk_rsp("rr1", 1, 1, 32'h0, 1'b0);
        chk_rsp("rr2", 2, 0, 32'h33, 1'b0);
        chk_rsp("rr3", 3, 1, 32'h11, 1'b0);

        clear_mon();
        q1.push_back('{1'b1, 6'h3F, 32'h5, 0, 1'b1});
        wait_idle(20);
        chk_rsp("slverr", 0, 1, 32'h0, 1'b1);
        chkb("slverr_psel_low", bus.psel, 1'b0);

        clear_mon();
        q0.push_back('{1'b0, 6'h01, 32'h0, 100, 1'b0});
        wait_idle(40);
        chk("to_pen_cycles", 32'(pen_cnt), 32'd15);
        chk("to_psel_cycles", 32'(psel_cnt), 32'd16);
        chk_rsp("to_rsp", 0, 0, 32'h0, 1'b1);
        chkb("to_psel_low", bus.psel, 1'b0);

        clear_mon();
        q0.push_back('{1'b1, 6'h05, 32'hCAFE, 20, 1'b0});
        n = 0;
        while (!(m_busy && m_age == 3) && n < 20) begin
            @(posedge pclk);
            #3;
            n++;
        end
        chkb("mid_reach_access2", n < 20, 1'b1);
        chkb("mid_penable_before", bus.penable, 1'b1);
        reset_pulse();
        chkb("mid_psel_after", bus.psel, 1'b0);
        chkb("mid_penable_after", bus.penable, 1'b0);
        repeat (3) @(posedge pclk);
        #3;
        chk("mid_no_rsp", 32'(rlog.size()), 32'd0);
        clear_mon();
        q0.push_back('{1'b0, 6'h00, 32'h0, 1, 1'b0});
        wait_idle(20);
        chk("post_psel_cycles", 32'(psel_cnt), 32'd3);
        chk_rsp("post_rsp", 0, 0, 32'hA5A5A5A5, 1'b0);

        repeat (2) @(posedge pclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter WAIT_MAX, default 15, maximum ACCESS cycles without pready before timeout.
REQ-004 SHALL have a single clock, pclk; the reset is preset, synchronous and active-high.
REQ-005 pclk  input  1  clock; all state updates on its rising edge.
REQ-006 preset  input  1  synchronous, active-high reset.
REQ-007 reqN_valid (N=0,1)  input  1  requester N has a transfer pending.
REQ-008 reqN_ready  output  1  requester N's transfer accepted this cycle.
REQ-009 reqN_write  input  1  1=write, 0=read.
REQ-010 reqN_addr  input  ADDR_W  transfer address.
REQ-011 reqN_wdata  input  DATA_W  write data.
REQ-012 rspN_valid  output  1  one-cycle completion strobe to requester N.
REQ-013 rspN_rdata  output  DATA_W  read data; 0 for writes.
REQ-014 rspN_err  output  1  pslvrr or timeout on the completed transfer.
REQ-015 paddr, pwrite, pwdata  output  ADDR_W/1/DATA_W  APB address, direction and write data, registered.
REQ-016 psel, penable  output  1  APB select and enable, registered.
REQ-017 prdata, pready, pslvrr  input  DATA_W/1/1  APB slave read data, ready and error.

Function
REQ-018 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE.
REQ-019 IDLE: psel=0, penable=0; if any reqN_valid, SHALL assert reqN_ready for exactly one granted requester (combinational), latch its write/addr/wdata and grant ID, and go to SETUP.
REQ-020 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it.
REQ-021 SETUP: psel=1, penable=0 for exactly one cycle; paddr, pwrite and pwdata SHALL be stable from SETUP through the end of ACCESS.
REQ-022 ACCESS: psel=1, penable=1 until pready=1 is sampled; then next state is IDLE.
REQ-023 On pready in ACCESS SHALL, on the next cycle, pulse rsp<grant>_valid for one cycle with rdata=prdata (reads) or 0 (writes) and err=pslvrr.
REQ-024 If ACCESS lasts WAIT_MAX cycles without pready, SHALL return to IDLE and pulse rsp_valid with err=1 and rdata=0.
REQ-025 Minimum transfer is 3 cycles (IDLE accept, SETUP, ACCESS); psel SHALL drop for at least one IDLE cycle between transfers.
REQ-026 reqN_valid changes outside IDLE SHALL be ignored; requests are never queued beyond the one latched.
REQ-027 pready or pslvrr outside ACCESS SHALL be ignored.
REQ-028 rsp to requester N and reqN_ready for the next transfer MAY coincide in the same IDLE cycle.

Reset
REQ-029 While preset=1, SHALL set the state to IDLE, drive psel, penable, pwrite, paddr, pwdata and all reqN_ready, rspN_valid, rspN_rdata and rspN_err to 0, and clear the timeout counter.
REQ-030 Reset SHALL set the last-grant pointer to 1 so that requester 0 wins the first contention.
REQ-031 Reset mid-transfer SHALL abandon the transfer with no rsp pulse; psel=0 from the first cycle after the reset edge.

Structure
REQ-032 The shared package apb_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS) and the ADDR_W/DATA_W defaults.
REQ-033 Round-robin grant logic SHALL be a sub-module apb_rr_arbiter (2 requests, pointer, grant one-hot).

Verification
REQ-034 Scenario: req0 write addr 0x00 data 0xA5A5A5A5, slave pready in first ACCESS -> psel 2 cycles, penable 1 cycle, rsp0_valid next cycle with err=0.
REQ-035 Scenario: req0 read addr 0x00 after the write above -> rsp0_rdata=0xA5A5A5A5, err=0, 3-cycle transfer.
REQ-036 Scenario: req0 and req1 valid together from reset, held for 4 transfers -> grants 0,1,0,1, each in order.
REQ-037 Scenario: write to addr 0x3F with slave pslvrr=1 -> rsp_err=1, FSM back to IDLE.
REQ-038 Scenario: pready held 0 -> exactly 15 ACCESS cycles, then rsp_err=1, rdata=0, psel=0.
REQ-039 Scenario: preset asserted in 2nd ACCESS cycle -> psel/penable 0 the next cycle, no rspN_valid, and the next transfer proceeds normally.
